vector_stream_reader: RTL
=========================

VECTOR_STREAM_READER -- requirements
Module: vector_stream_reader

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 4: pixel width in bits.
REQ-002 SHALL have parameter RAM_ADDR_BITS_VECTOR, default 6: ROM address width.
REQ-003 SHALL have parameter START_ADDR, default 0: first pixel address read.
REQ-004 SHALL have parameter END_ADDR, default 63: last pixel address read, inclusive, with START_ADDR <= END_ADDR.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port start, input, 1 bit: one-cycle request to stream the vector.
REQ-008 SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until the cycle done pulses.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse after the final pixel is accepted.
REQ-010 SHALL have port addr_vector, output, RAM_ADDR_BITS_VECTOR bits: address to the asynchronous-read vector ROM.
REQ-011 SHALL have port data_in, input, RAM_WIDTH bits: ROM read data, valid combinationally for the current addr_vector.
REQ-012 SHALL have port out_data, output, RAM_WIDTH bits: registered pixel to the CNN datapath.
REQ-013 SHALL have port out_valid, output, 1 bit: out_data holds a pixel.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts; a transfer occurs when out_valid and out_ready are both high.

Function
REQ-015 SHALL implement FSM states IDLE, STREAM and FLUSH.
REQ-016 SHALL move IDLE->STREAM on start with addr_vector = START_ADDR; start SHALL be ignored in STREAM and FLUSH.
REQ-017 SHALL, in STREAM, load out_data <= data_in and set out_valid = 1 whenever out_valid = 0 or out_ready = 1.
REQ-018 SHALL increment addr_vector by 1 on each load, except when addr_vector = END_ADDR, where it enters FLUSH with no increment and no wrap.
REQ-019 SHALL, in FLUSH, clear out_valid on transfer, pulse done the following cycle, and return to IDLE with addr_vector = START_ADDR.
REQ-020 SHALL hold out_data and out_valid stable while out_valid = 1 and out_ready = 0; no pixel is dropped or duplicated.
REQ-021 SHALL deliver the first pixel with out_valid high 2 cycles after the start cycle.
REQ-022 SHALL sustain 1 pixel per cycle while out_ready stays high; a full stream completes in (END_ADDR - START_ADDR + 1) transfers.
REQ-023 SHALL correctly handle START_ADDR = END_ADDR: exactly one pixel, then done.

Reset
REQ-024 SHALL drive the following values on rst, including mid-stream: state = IDLE, out_valid = 0, out_data = 0, done = 0, busy = 0, addr_vector = START_ADDR.
REQ-025 SHALL take rst priority over start in the same cycle.
REQ-026 SHALL, after reset, never resume a partial stream; a new start restarts at START_ADDR.

Configuration
REQ-027 SHALL, with VECTOR_STREAM_LAST_EN defined, add output port out_last (1 bit), high with out_valid only for the pixel read from END_ADDR, and 0 on reset.
REQ-028 SHALL, without VECTOR_STREAM_LAST_EN, omit out_last; all other behaviour SHALL be identical.

Structure
REQ-029 SHALL place the default RAM_WIDTH and address-width constants and the FSM state typedef in shared package vector_stream_pkg.
REQ-030 SHALL contain no sub-module; the ROM is external and instantiated alongside the block in system and bench.

Verification
REQ-031 SHALL cover a full stream: ROM[i] = i mod 16, defaults, out_ready = 1, start in cycle 0 -> out_valid from cycle 2, pixels 0,1,...,15,0,... for 64 transfers, done pulse in the cycle after the last transfer, busy low afterwards.
REQ-032 SHALL cover backpressure: out_ready low for the 3 cycles while pixel 5 is presented -> out_data = 5 held, then 6 follows; 64 transfers total with no loss or duplication.
REQ-033 SHALL cover a single pixel: START_ADDR = END_ADDR = 10 -> exactly one transfer with value 0xA (out_last = 1 when the macro is defined), then done.
REQ-034 SHALL cover reset mid-stream: rst after transfer 20 -> next cycle out_valid = 0, busy = 0, addr_vector = 0; a following start restreams from pixel 0.
REQ-035 SHALL cover start while busy: a second start at transfer 30 -> ignored; exactly 64 transfers and one done pulse.
REQ-036 SHALL cover both builds: with and without VECTOR_STREAM_LAST_EN, the transfer sequence is identical, and out_last appears only at address 63 when enabled.

Source files
------------

// File: rtl/vector_stream_pkg.sv
// Shared constants and FSM state type for the vector stream reader.
package vector_stream_pkg;

    localparam int unsigned VS_RAM_WIDTH  = 4;
    localparam int unsigned VS_ADDR_BITS  = 6;
    localparam int unsigned VS_START_ADDR = 0;
    localparam int unsigned VS_END_ADDR   = 63;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } vs_state_t;

endpackage

// File: rtl/vector_stream_reader.sv
// Streams pixels START_ADDR..END_ADDR from an async-read vector ROM onto a valid/ready port.
// Optional out_last flag on the END_ADDR pixel when VECTOR_STREAM_LAST_EN is defined.
module vector_stream_reader
    import vector_stream_pkg::*;
#(
    parameter int unsigned RAM_WIDTH            = VS_RAM_WIDTH,
    parameter int unsigned RAM_ADDR_BITS_VECTOR = VS_ADDR_BITS,
    parameter int unsigned START_ADDR           = VS_START_ADDR,
    parameter int unsigned END_ADDR             = VS_END_ADDR
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic [RAM_ADDR_BITS_VECTOR-1:0] addr_vector,
    input  logic [RAM_WIDTH-1:0]            data_in,
    output logic [RAM_WIDTH-1:0]            out_data,
    output logic                            out_valid,
    input  logic                            out_ready
`ifdef VECTOR_STREAM_LAST_EN
    ,
    output logic                            out_last
`endif
);

    localparam logic [RAM_ADDR_BITS_VECTOR-1:0] START_A = RAM_ADDR_BITS_VECTOR'(START_ADDR);
    localparam logic [RAM_ADDR_BITS_VECTOR-1:0] END_A   = RAM_ADDR_BITS_VECTOR'(END_ADDR);

    vs_state_t                       state, state_next;
    logic [RAM_ADDR_BITS_VECTOR-1:0] addr_next;
    logic [RAM_WIDTH-1:0]            data_next;
    logic                            valid_next;
    logic                            done_next;
    logic                            busy_next;
    logic                            at_end;
`ifdef VECTOR_STREAM_LAST_EN
    logic                            last_next;
`endif

    assign at_end = (addr_vector == END_A);

    // Next-state and next-output logic; a load happens whenever the output register is free.
    always_comb begin
        state_next = state;
        addr_next  = addr_vector;
        data_next  = out_data;
        valid_next = out_valid;
        done_next  = 1'b0;
        busy_next  = busy;
`ifdef VECTOR_STREAM_LAST_EN
        last_next  = out_last;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = STREAM;
                    busy_next  = 1'b1;
                    addr_next  = START_A;
                end
            end
            STREAM: begin
                if (!out_valid || out_ready) begin
                    data_next  = data_in;
                    valid_next = 1'b1;
`ifdef VECTOR_STREAM_LAST_EN
                    last_next  = at_end;
`endif
                    if (at_end) begin
                        state_next = FLUSH;
                    end else begin
                        addr_next = addr_vector + RAM_ADDR_BITS_VECTOR'(1);
                    end
                end
            end
            FLUSH: begin
                if (out_valid && out_ready) begin
                    valid_next = 1'b0;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                    addr_next  = START_A;
`ifdef VECTOR_STREAM_LAST_EN
                    last_next  = 1'b0;
`endif
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any partial stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr_vector <= START_A;
            out_data    <= '0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
`ifdef VECTOR_STREAM_LAST_EN
            out_last    <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            addr_vector <= addr_next;
            out_data    <= data_next;
            out_valid   <= valid_next;
            done        <= done_next;
            busy        <= busy_next;
`ifdef VECTOR_STREAM_LAST_EN
            out_last    <= last_next;
`endif
        end
    end

endmodule
